// File: rtl/lod_pkg.sv
// Shared constants and helpers for the pipelined leading/trailing-one detector.
package lod_pkg;

    localparam logic LOD_MODE_LEAD  = 1'b0;
    localparam logic LOD_MODE_TRAIL = 1'b1;

    localparam int unsigned LOD_GROUP = 4;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            v = v >> 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lod_group4.sv
// Combinational 4-bit encoder: reports any-set and the local index of the first one.
module lod_group4
    import lod_pkg::*;
(
    input  logic [3:0] i_slice,
    input  logic       i_mode,
    output logic       o_any,
    output logic [1:0] o_idx
);

    always_comb begin
        o_any = |i_slice;
        o_idx = 2'd0;
        if (i_mode == LOD_MODE_LEAD) begin
            casez (i_slice)
                4'b1???: o_idx = 2'd3;
                4'b01??: o_idx = 2'd2;
                4'b001?: o_idx = 2'd1;
                default: o_idx = 2'd0;
            endcase
        end else begin
            casez (i_slice)
                4'b???1: o_idx = 2'd0;
                4'b??10: o_idx = 2'd1;
                4'b?100: o_idx = 2'd2;
                4'b1000: o_idx = 2'd3;
                default: o_idx = 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/lead_one_detector_pipe.sv
// Two-stage pipelined leading/trailing-one detector with valid/ready on both sides.
// Stage 1 registers per-group encodings; stage 2 picks the winning group and forms position/count.
module lead_one_detector_pipe
    import lod_pkg::*;
#(
    parameter  int unsigned WIDTH = 24,
    localparam int unsigned PW    = clog2(WIDTH),
    localparam int unsigned CW    = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_number,
    input  logic             in_prev_validity,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    out_position,
    output logic [CW-1:0]    out_count,
    output logic             out_validity
);

    localparam int unsigned NG = WIDTH / LOD_GROUP;

    logic [NG-1:0]      w_any;
    logic [NG-1:0][1:0] w_idx;

    logic [NG-1:0]      r_any;
    logic [NG-1:0][1:0] r_idx;
    logic               r_prev;
    logic               r_mode;
    logic               r_s1_valid;

    logic               r_out_valid;
    logic [PW-1:0]      r_out_position;
    logic [CW-1:0]      r_out_count;
    logic               r_out_validity;

    logic               w_s2_adv;
    logic               w_s1_adv;
    logic               w_found;
    logic [PW-1:0]      w_scan_pos;
    logic               w_res_valid;
    logic [PW-1:0]      w_res_pos;
    logic [CW-1:0]      w_res_cnt;

    for (genvar g = 0; g < NG; g++) begin : g_grp
        lod_group4 u_grp (
            .i_slice (in_number[g*LOD_GROUP +: LOD_GROUP]),
            .i_mode  (in_mode),
            .o_any   (w_any[g]),
            .o_idx   (w_idx[g])
        );
    end

    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv && !flush;

    // Stage 1 data needs no reset: it is only consumed when r_s1_valid is set.
    always_ff @(posedge clk) begin
        if (w_s1_adv) begin
            r_any  <= w_any;
            r_idx  <= w_idx;
            r_prev <= in_prev_validity;
            r_mode <= in_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
        end
    end

    // Later hits overwrite earlier ones, so scan order decides highest vs lowest group.
    always_comb begin
        w_found    = 1'b0;
        w_scan_pos = '0;
        if (r_mode == LOD_MODE_LEAD) begin
            for (int g = 0; g < int'(NG); g++) begin
                if (r_any[g]) begin
                    w_found    = 1'b1;
                    w_scan_pos = PW'(unsigned'(g) * LOD_GROUP) + PW'(r_idx[g]);
                end
            end
        end else begin
            for (int g = int'(NG) - 1; g >= 0; g--) begin
                if (r_any[g]) begin
                    w_found    = 1'b1;
                    w_scan_pos = PW'(unsigned'(g) * LOD_GROUP) + PW'(r_idx[g]);
                end
            end
        end
    end

    always_comb begin
        w_res_valid = w_found && r_prev;
        w_res_pos   = '0;
        w_res_cnt   = CW'(WIDTH);
        if (w_res_valid) begin
            w_res_pos = w_scan_pos;
            if (r_mode == LOD_MODE_LEAD) begin
                w_res_cnt = CW'(WIDTH - 1) - CW'(w_scan_pos);
            end else begin
                w_res_cnt = CW'(w_scan_pos);
            end
        end
    end

    // Data is zeroed whenever the stage empties so idle outputs always read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid    <= 1'b0;
            r_out_position <= '0;
            r_out_count    <= '0;
            r_out_validity <= 1'b0;
        end else if (flush) begin
            r_out_valid    <= 1'b0;
            r_out_position <= '0;
            r_out_count    <= '0;
            r_out_validity <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_position <= w_res_pos;
                r_out_count    <= w_res_cnt;
                r_out_validity <= w_res_valid;
            end else begin
                r_out_position <= '0;
                r_out_count    <= '0;
                r_out_validity <= 1'b0;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_position = r_out_position;
    assign out_count    = r_out_count;
    assign out_validity = r_out_validity;

endmodule

// File: tb/tb_lead_one_detector_pipe.sv
// Directed and reference-model bench for lead_one_detector_pipe at WIDTH=24.
module tb_lead_one_detector_pipe;

    localparam int unsigned WIDTH = 24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_number;
    logic        in_prev_validity;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_position;
    logic [4:0]  out_count;
    logic        out_validity;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lead_one_detector_pipe #(.WIDTH(WIDTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_number        (in_number),
        .in_prev_validity (in_prev_validity),
        .in_mode          (in_mode),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_position     (out_position),
        .out_count        (out_count),
        .out_validity     (out_validity)
    );

    function automatic void model(input logic [23:0] n, input logic m, input logic p,
                                  output logic [4:0] pos, output logic [4:0] cnt, output logic v);
        int hit;
        hit = -1;
        for (int k = 0; k < 24; k++) begin
            int i;
            i = m ? k : 23 - k;
            if (hit < 0 && n[i]) hit = i;
        end
        if (hit < 0 || !p) begin
            v = 1'b0; pos = 5'd0; cnt = 5'd24;
        end else begin
            v = 1'b1; pos = 5'(hit);
            cnt = m ? 5'(hit) : 5'(23 - hit);
        end
    endfunction

    task automatic test_reset();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        total++; if (out_position !== 5'd0) begin bad++; $display("FAIL rst_pos got=%0d exp=0", out_position); end
        total++; if (out_count !== 5'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", out_count); end
        total++; if (out_validity !== 1'b0) begin bad++; $display("FAIL rst_validity got=%b exp=0", out_validity); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_lead();
        @(negedge clk);
        in_number = 24'h000F00; in_mode = 1'b0; in_prev_validity = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lead_early got=%b exp=0", out_valid); end
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lead_latency got=%b exp=1", out_valid); end
        total++; if (out_position !== 5'd11) begin bad++; $display("FAIL lead_pos got=%0d exp=11", out_position); end
        total++; if (out_count !== 5'd12) begin bad++; $display("FAIL lead_cnt got=%0d exp=12", out_count); end
        total++; if (out_validity !== 1'b1) begin bad++; $display("FAIL lead_validity got=%b exp=1", out_validity); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lead_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_trail();
        logic [23:0] nums [2] = '{24'h000F00, 24'h800000};
        logic [4:0]  ep   [2] = '{5'd8, 5'd23};
        logic [4:0]  ec   [2] = '{5'd8, 5'd23};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_number = nums[i]; in_mode = 1'b1; in_prev_validity = 1'b1; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL trail_valid[%0d] got=%b exp=1", i, out_valid); end
            total++; if (out_position !== ep[i]) begin bad++; $display("FAIL trail_pos[%0d] got=%0d exp=%0d", i, out_position, ep[i]); end
            total++; if (out_count !== ec[i]) begin bad++; $display("FAIL trail_cnt[%0d] got=%0d exp=%0d", i, out_count, ec[i]); end
            total++; if (out_validity !== 1'b1) begin bad++; $display("FAIL trail_validity[%0d] got=%b exp=1", i, out_validity); end
        end
    endtask

    task automatic test_zero_chain();
        logic [23:0] nums  [2] = '{24'h000000, 24'h000001};
        logic        prevs [2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_number = nums[i]; in_mode = 1'b0; in_prev_validity = prevs[i]; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL zero_valid[%0d] got=%b exp=1", i, out_valid); end
            total++; if (out_validity !== 1'b0) begin bad++; $display("FAIL zero_validity[%0d] got=%b exp=0", i, out_validity); end
            total++; if (out_position !== 5'd0) begin bad++; $display("FAIL zero_pos[%0d] got=%0d exp=0", i, out_position); end
            total++; if (out_count !== 5'd24) begin bad++; $display("FAIL zero_cnt[%0d] got=%0d exp=24", i, out_count); end
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] words [4] = '{24'h800000, 24'h000001, 24'h010000, 24'h000010};
        logic [4:0]  ep    [4] = '{5'd23, 5'd0, 5'd16, 5'd4};
        logic [4:0]  ec    [4] = '{5'd0, 5'd23, 5'd7, 5'd19};
        int sent;
        int got;
        bit saw_block;
        sent = 0; got = 0; saw_block = 1'b0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            out_ready = !(c >= 2 && c <= 4);
            if (sent < 4) begin
                in_valid = 1'b1; in_number = words[sent]; in_mode = 1'b0; in_prev_validity = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                total++; if (out_position !== ep[got]) begin bad++; $display("FAIL bp_pos[%0d] cyc=%0d got=%0d exp=%0d", got, c, out_position, ep[got]); end
                total++; if (out_count !== ec[got]) begin bad++; $display("FAIL bp_cnt[%0d] cyc=%0d got=%0d exp=%0d", got, c, out_count, ec[got]); end
                if (out_ready) got++;
            end
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (got != 4) begin bad++; $display("FAIL bp_results got=%0d exp=4", got); end
        total++; if (saw_block !== 1'b1) begin bad++; $display("FAIL bp_in_ready_low got=%b exp=1", saw_block); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        out_ready = 1'b0;
        in_number = 24'h000100; in_mode = 1'b0; in_prev_validity = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_number = 24'h000002;
        @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b1 || out_position !== 5'd8) begin bad++; $display("FAIL flush_pre got=%b/%0d exp=1/8", out_valid, out_position); end
        flush = 1'b1; in_number = 24'h400000;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_clear got=%b exp=0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_stale[%0d] got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0;
        in_number = 24'h000040; in_mode = 1'b1; in_prev_validity = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_number = 24'h000200;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b1 || out_position !== 5'd6) begin bad++; $display("FAIL rmid_pre got=%b/%0d exp=1/6", out_valid, out_position); end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
        total++; if (out_position !== 5'd0) begin bad++; $display("FAIL rmid_pos got=%0d exp=0", out_position); end
        total++; if (out_count !== 5'd0) begin bad++; $display("FAIL rmid_cnt got=%0d exp=0", out_count); end
        total++; if (out_validity !== 1'b0) begin bad++; $display("FAIL rmid_validity got=%b exp=0", out_validity); end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale[%0d] got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_full_rate();
        logic [23:0] nums  [100];
        logic        modes [100];
        logic        prevs [100];
        logic [31:0] r;
        logic [4:0]  ep;
        logic [4:0]  ec;
        logic        ev;
        for (int i = 0; i < 100; i++) begin
            int sh;
            r  = $urandom();
            sh = $urandom_range(0, 24);
            if ($urandom_range(0, 1) == 1) r = r >> sh;
            else r = r << sh;
            nums[i]  = r[23:0];
            modes[i] = 1'($urandom_range(0, 1));
            prevs[i] = ($urandom_range(0, 9) != 0);
        end
        nums[5] = 24'h000000;
        nums[6] = 24'h800001;
        out_ready = 1'b1;
        for (int c = 0; c < 102; c++) begin
            @(negedge clk);
            if (c < 100) begin
                in_valid = 1'b1; in_number = nums[c]; in_mode = modes[c]; in_prev_validity = prevs[c];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 100) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fr_in_ready cyc=%0d got=%b exp=1", c, in_ready); end
            end
            if (c >= 2) begin
                model(nums[c-2], modes[c-2], prevs[c-2], ep, ec, ev);
                total++;
                if (out_valid !== 1'b1 || out_position !== ep || out_count !== ec || out_validity !== ev) begin
                    bad++;
                    $display("FAIL fr_result word=%0d got=%b/%0d/%0d/%b exp=1/%0d/%0d/%b",
                             c - 2, out_valid, out_position, out_count, out_validity, ep, ec, ev);
                end
            end
        end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fr_drain got=%b exp=0", out_valid); end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_number = '0;
        in_prev_validity = 1'b0; in_mode = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_lead();
        test_trail();
        test_zero_chain();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_full_rate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
